slot_bcd_display: RTL and testbench
===================================

SLOT_BCD_DISPLAY -- requirements
Module: slot_bcd_display

Interface
REQ-001 Parameter BLINK_DIV, default 25_000_000, is the number of clk cycles per blink half-period (0.5 s at 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 value  input  10  binary reel result from the random-number stage, nominally 0..999.
REQ-005 won  input  1  win flag from the game controller, level-sensitive.
REQ-006 hex2 / hex1 / hex0  output  7 each  seven-segment drive, active-low, bit0=a … bit6=g, for hundreds / tens / ones.
REQ-007 led_won  output  1  win indicator LED, active-high.
REQ-008 done  output  1  one-cycle pulse when the display registers take a new conversion.

Function
REQ-009 Controller states are IDLE, SHIFT and UPDATE; the state register is 2 bits, and unused encodings return to IDLE on the next clock.
REQ-010 IDLE (1 cycle) captures value into a 10-bit shift register, clears the 12-bit BCD register and the 4-bit iteration count, then moves to SHIFT.
REQ-011 If value > 999 at capture, the captured value is 999 (clamp).
REQ-012 Each SHIFT cycle first adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by one and increments the count.
REQ-013 SHIFT moves to UPDATE after the 10th shift.
REQ-014 UPDATE (1 cycle) latches the three BCD nibbles into the digit registers, asserts done, then moves to IDLE.
REQ-015 A full conversion takes 12 cycles; hex outputs reflect the value sampled in IDLE on the clock edge that ends UPDATE.
REQ-016 Conversion runs continuously; a value change mid-conversion does not affect the conversion in progress and is picked up at the next IDLE.
REQ-017 Digit-to-segment decode is combinational from the digit registers: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any nibble >9 decodes to blank (1111111).
REQ-018 Blink counter rules:
  - while won=1, a 32-bit blink counter increments each clk;
  - on reaching BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
REQ-019 While won=1 and blink_phase=0, all three hex outputs are blank (1111111); otherwise the decoded digits are shown.
REQ-020 led_won equals won registered by one clk.
REQ-021 When won=0, the blink counter is held at 0 and blink_phase at 1 (digits shown), so each win starts with a full visible half-period.
REQ-022 won rising and a counter wrap in the same cycle: the counter clears and blink_phase stays 1.

Reset
REQ-023 On rst=1 at posedge clk:
  - state=IDLE, digit registers=0, BCD/shift/count registers=0;
  - blink counter=0, blink_phase=1;
  - led_won=0, done=0;
  - hex2/hex1/hex0 = 1000000 ("000").
REQ-024 rst takes priority over all other inputs; rst mid-conversion aborts that conversion with no done pulse and no digit update.
REQ-025 The first conversion begins in the first IDLE cycle after rst deasserts.

Verification
REQ-026 Reset then value=10'd527 held, won=0 -> done pulses every 12 cycles; hex2=0010010, hex1=0100100, hex0=1111000.
REQ-027 value=10'd1023 -> displayed 999: all three hex = 0010000.
REQ-028 value changes 123->456 during a SHIFT cycle -> next done shows 123; the following done shows 456.
REQ-029 BLINK_DIV=4, value=777, won=1 for 20 cycles:
  - hex outputs alternate shown/blank every 4 cycles, starting with shown;
  - led_won=1 one cycle after won rises;
  - on won=0, digits are steady within one cycle.
REQ-030 rst asserted at the 5th SHIFT cycle of a conversion of 999 after 000 was displayed -> no done pulse; hex stays 000; the first conversion after release takes 12 cycles.
REQ-031 value=0 -> all hex = 1000000 and done keeps pulsing at its 12-cycle period.

Source files
------------

// File: rtl/slot_bcd_display.sv
// Purpose: turns the 10-bit reel result (clamped to 999) into three 7-segment digits and blinks them while a win is shown.
// Latency: 12 cycles per conversion (IDLE, 10 x SHIFT, UPDATE); the display and the done pulse change on the edge that ends UPDATE.
// Backpressure: none; conversions run back to back, and value is sampled only in IDLE.
module slot_bcd_display #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] value,
    input  logic       won,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       led_won,
    output logic       done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
    localparam logic [3:0]  LAST_SHIFT = 4'd9;

    logic [1:0]  state_q, state_d;
    logic [9:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  dig2_q, dig2_d;
    logic [3:0]  dig1_q, dig1_d;
    logic [3:0]  dig0_q, dig0_d;
    logic        done_q, done_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic        led_won_q;

    logic [11:0] bcd_adj;
    logic [21:0] shift_v;
    logic        blank;

    // Double-dabble correction: a nibble of 5 or more would carry past 9 after doubling.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Active-low segment pattern, bit0 = a ... bit6 = g; anything above 9 is blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Conversion controller: capture in IDLE, shift-add-3 for ten cycles, publish in UPDATE.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig2_d  = dig2_q;
        dig1_d  = dig1_q;
        dig0_d  = dig0_q;
        done_d  = 1'b0;
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shift_v = {bcd_adj, bin_q} << 1;
        case (state_q)
            S_IDLE: begin
                bin_d   = (value > 10'd999) ? 10'd999 : value;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = shift_v;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                dig2_d  = bcd_q[11:8];
                dig1_d  = bcd_q[7:4];
                dig0_d  = bcd_q[3:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Blink timing: held visible while not winning; a wrap coinciding with the win's first cycle keeps the digits visible.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!won) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = led_won_q ? ~blink_phase_q : blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            dig2_q        <= '0;
            dig1_q        <= '0;
            dig0_q        <= '0;
            done_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_won_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            dig2_q        <= dig2_d;
            dig1_q        <= dig1_d;
            dig0_q        <= dig0_d;
            done_q        <= done_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_won_q     <= won;
        end
    end

    // Output decode: blanking follows the live win flag so digits return within the cycle won drops.
    always_comb begin
        blank = won && !blink_phase_q;
        hex2  = blank ? 7'b1111111 : seg7(dig2_q);
        hex1  = blank ? 7'b1111111 : seg7(dig1_q);
        hex0  = blank ? 7'b1111111 : seg7(dig0_q);
    end

    assign led_won = led_won_q;
    assign done    = done_q;

endmodule

// File: tb/tb_slot_bcd_display.sv
// Purpose: exercises slot_bcd_display with directed scenarios and random stimulus against a timeline reference model.
// Latency: outputs are compared 1 time unit after every rising edge.
// Backpressure: not applicable; inputs change only after each comparison.
module tb_slot_bcd_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] value;
    logic       won;
    logic [6:0] hex2, hex1, hex0;
    logic       led_won, done;

    int errors = 0;
    int checks = 0;

    // Reference model: edges since reset release, captured/displayed numbers, win duration.
    int n_edge;
    int cap;
    int disp;
    int t_won;
    bit done_e;
    bit led_e;

    always #5 clk = ~clk;

    slot_bcd_display #(.BLINK_DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .won     (won),
        .hex2    (hex2),
        .hex1    (hex1),
        .hex0    (hex0),
        .led_won (led_won),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", tag, got, exp, $time, n_edge);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d, input bit show);
        logic [6:0] s;
        case (d)
            0:       s = 7'b1000000;
            1:       s = 7'b1111001;
            2:       s = 7'b0100100;
            3:       s = 7'b0110000;
            4:       s = 7'b0011001;
            5:       s = 7'b0010010;
            6:       s = 7'b0000010;
            7:       s = 7'b1111000;
            8:       s = 7'b0000000;
            9:       s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return show ? s : 7'b1111111;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare every output.
    task automatic tick();
        bit show;
        @(posedge clk);
        if (rst) begin
            n_edge = 0;
            cap    = 0;
            disp   = 0;
            done_e = 1'b0;
            t_won  = 0;
            led_e  = 1'b0;
        end else begin
            n_edge++;
            if (n_edge % 12 == 1) cap = (int'(value) > 999) ? 999 : int'(value);
            done_e = (n_edge % 12 == 0);
            if (done_e) disp = cap;
            t_won = won ? t_won + 1 : 0;
            led_e = won;
        end
        #1;
        show = !won || ((t_won / DIV) % 2 == 0);
        check("hex2", 32'(hex2), 32'(exp_seg(disp / 100, show)));
        check("hex1", 32'(hex1), 32'(exp_seg((disp / 10) % 10, show)));
        check("hex0", 32'(hex0), 32'(exp_seg(disp % 10, show)));
        check("done", 32'(done), 32'(done_e));
        check("led_won", 32'(led_won), 32'(led_e));
    endtask

    initial begin
        n_edge = 0; cap = 0; disp = 0; t_won = 0; done_e = 1'b0; led_e = 1'b0;
        rst   = 1'b1;
        value = 10'd0;
        won   = 1'b0;
        repeat (3) tick();

        // Steady 527, then out-of-range input clamped to 999.
        rst   = 1'b0;
        value = 10'd527;
        repeat (30) tick();
        value = 10'd1023;
        repeat (26) tick();

        // Mid-conversion change: 123 captured, 456 picked up at the next IDLE.
        value = 10'd123;
        repeat (15) tick();
        value = 10'd456;
        repeat (30) tick();

        // Win display blinking and release.
        value = 10'd777;
        repeat (14) tick();
        won = 1'b1;
        repeat (20) tick();
        won = 1'b0;
        repeat (5) tick();

        // Reset during the fifth SHIFT of a 999 conversion after 000 was shown.
        rst = 1'b1;
        value = 10'd0;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        value = 10'd999;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (14) tick();

        // Zero keeps converting at the normal period.
        value = 10'd0;
        repeat (30) tick();

        // Random mix of values, win periods and occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 7) == 0) value = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 39) == 0) won = ~won;
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        won = 1'b0;
        repeat (13) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
